// File: rtl/dmem_arbiter.sv
// Single data-memory port shared by the core load/store path and a debug host.
// The core normally wins; a starvation counter forces debug through after STARVE_MAX lost cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             force_dbg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_stall  = cpu_req;
        dbg_gnt    = 1'b0;
        dbg_rvalid = 1'b0;
        cpu_rdata  = mem_rdata;
        dbg_rdata  = mem_rdata;
        force_dbg  = dbg_req && (starve_cnt_q == STARVE_LIM);

        // Reset gates every issue so nothing reaches memory before state is known.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_req && !force_dbg) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        cpu_stall = !cpu_we;
                        if (!cpu_we) state_d = CPU_RD;
                    end else if (dbg_req) begin
                        dbg_gnt   = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = dbg_we;
                        mem_addr  = dbg_addr;
                        mem_wdata = dbg_wdata;
                        if (!dbg_we) state_d = DBG_RD;
                    end
                end
                // The core's held request here is the completing load, not a new one.
                CPU_RD: begin
                    cpu_stall = 1'b0;
                    state_d   = IDLE;
                end
                DBG_RD: begin
                    dbg_rvalid = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (dbg_req && !dbg_gnt)
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 1'b1;
        else
            starve_cnt_d = '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model
// of the shared port, with a simple synchronous memory in the bench.
module tb_dmem_arbiter;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int SM = 4;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    // second instance with debug fixed priority; only its grant-side outputs are checked
    logic [DW-1:0] z_cpu_rdata, z_dbg_rdata, z_mem_wdata;
    logic          z_cpu_stall, z_dbg_gnt, z_dbg_rvalid, z_mem_en, z_mem_we;
    logic [AW-1:0] z_mem_addr;

    logic [DW-1:0] mem       [NW];
    logic [DW-1:0] init_val  [NW];
    logic [DW-1:0] model_mem [NW];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(z_dbg_gnt), .dbg_rdata(z_dbg_rdata), .dbg_rvalid(z_dbg_rvalid),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // memory reloads its initial image while reset is held
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_val[i];
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic reload_model;
        for (int i = 0; i < NW; i++) model_mem[i] = init_val[i];
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd2;
        #2;
        checks++;
        if ({mem_en, mem_we, dbg_gnt, dbg_rvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: en/we/gnt/rvalid=%b required 0000", {mem_en, mem_we, dbg_gnt, dbg_rvalid});
        end
        checks++;
        if (cpu_stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_stall_req1: cpu_stall=%b required 1", cpu_stall);
        end
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0;
        #2;
        checks++;
        if (cpu_stall !== 1'b0 || int'(dut.starve_cnt_q) != 0) begin
            failures++;
            $display("FAIL reset_stall_req0: cpu_stall=%b cnt=%0d required 0 0", cpu_stall, dut.starve_cnt_q);
        end
        @(negedge clk);
        rst = 1'b0;
        reload_model();
    endtask

    task automatic test_fixed_priority;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd0; cpu_wdata = 16'h1234;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd7; dbg_wdata = 16'hBEEF;
        #2;
        checks++;
        if (z_dbg_gnt !== 1'b1 || z_cpu_stall !== 1'b1 || z_mem_addr !== 3'd7) begin
            failures++;
            $display("FAIL starve0_dbg_wins: gnt=%b stall=%b addr=%0d required 1 1 7", z_dbg_gnt, z_cpu_stall, z_mem_addr);
        end
        checks++;
        if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 3'd0 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL simultaneous_cpu_wins: gnt=%b stall=%b addr=%0d en=%b required 0 0 0 1", dbg_gnt, cpu_stall, mem_addr, mem_en);
        end
        model_mem[0] = 16'h1234;
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic test_core_store;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd3; cpu_wdata = 16'hA5A5;
        #2;
        checks++;
        if ({mem_en, mem_we, cpu_stall} !== 3'b110 || mem_addr !== 3'd3 || mem_wdata !== 16'hA5A5) begin
            failures++;
            $display("FAIL core_store: en/we/stall=%b addr=%0d wdata=%h required 110 3 a5a5", {mem_en, mem_we, cpu_stall}, mem_addr, mem_wdata);
        end
        model_mem[3] = 16'hA5A5;
    endtask

    task automatic test_core_load;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd3;
        #2;
        checks++;
        if ({cpu_stall, mem_en, mem_we} !== 3'b110 || mem_addr !== 3'd3) begin
            failures++;
            $display("FAIL core_load_issue: stall/en/we=%b addr=%0d required 110 3", {cpu_stall, mem_en, mem_we}, mem_addr);
        end
        @(negedge clk);
        #2;
        checks++;
        if (cpu_stall !== 1'b0 || mem_en !== 1'b0 || cpu_rdata !== 16'hA5A5) begin
            failures++;
            $display("FAIL core_load_done: stall=%b en=%b rdata=%h required 0 0 a5a5", cpu_stall, mem_en, cpu_rdata);
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_dbg_read;
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd5;
        #2;
        checks++;
        if (dbg_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 3'd5) begin
            failures++;
            $display("FAIL dbg_read_grant: gnt=%b en=%b we=%b addr=%0d required 1 1 0 5", dbg_gnt, mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        dbg_req = 1'b0;
        #2;
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== model_mem[5] || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL dbg_read_data: rvalid=%b rdata=%h en=%b required 1 %h 0", dbg_rvalid, dbg_rdata, mem_en, model_mem[5]);
        end
        @(negedge clk);
        #2;
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL dbg_read_pulse: rvalid=%b required 0", dbg_rvalid);
        end
    endtask

    task automatic test_starvation;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b1;
            if (c < 5) begin
                cpu_addr = AW'(c);
                cpu_wdata = DW'($urandom);
            end
            dbg_req = (c <= 4); dbg_we = 1'b1; dbg_addr = 3'd6; dbg_wdata = 16'hD00D;
            #2;
            checks++;
            if (c < 4) begin
                if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== AW'(c) || int'(dut.starve_cnt_q) != c) begin
                    failures++;
                    $display("FAIL starve_core_c%0d: gnt=%b stall=%b addr=%0d cnt=%0d required 0 0 %0d %0d",
                             c, dbg_gnt, cpu_stall, mem_addr, dut.starve_cnt_q, c, c);
                end
                model_mem[c] = cpu_wdata;
            end else if (c == 4) begin
                if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_addr !== 3'd6 || mem_wdata !== 16'hD00D) begin
                    failures++;
                    $display("FAIL starve_forced: gnt=%b stall=%b addr=%0d wdata=%h required 1 1 6 d00d",
                             dbg_gnt, cpu_stall, mem_addr, mem_wdata);
                end
                model_mem[6] = 16'hD00D;
            end else begin
                if (int'(dut.starve_cnt_q) != 0 || dbg_gnt !== 1'b0 || mem_addr !== 3'd4 || cpu_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL starve_clear: cnt=%0d gnt=%b addr=%0d stall=%b required 0 0 4 0",
                             dut.starve_cnt_q, dbg_gnt, mem_addr, cpu_stall);
                end
                model_mem[4] = cpu_wdata;
            end
        end
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic test_dbg_during_load;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd2;
        #2;
        checks++;
        if (cpu_stall !== 1'b1 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL dl_load_issue: stall=%b en=%b required 1 1", cpu_stall, mem_en);
        end
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd1;
        #2;
        checks++;
        if (mem_en !== 1'b0 || dbg_gnt !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== model_mem[2]) begin
            failures++;
            $display("FAIL dl_cpu_rd: en=%b gnt=%b stall=%b rdata=%h required 0 0 0 %h", mem_en, dbg_gnt, cpu_stall, cpu_rdata, model_mem[2]);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        #2;
        checks++;
        if (dbg_gnt !== 1'b1 || int'(dut.starve_cnt_q) != 1 || mem_addr !== 3'd1) begin
            failures++;
            $display("FAIL dl_dbg_grant: gnt=%b cnt=%0d addr=%0d required 1 1 1", dbg_gnt, dut.starve_cnt_q, mem_addr);
        end
        @(negedge clk);
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd7; cpu_wdata = 16'h7777;
        #2;
        checks++;
        if (dbg_rvalid !== 1'b1 || cpu_stall !== 1'b1 || mem_en !== 1'b0 || dbg_rdata !== model_mem[1]) begin
            failures++;
            $display("FAIL dl_dbg_rd: rvalid=%b stall=%b en=%b rdata=%h required 1 1 0 %h", dbg_rvalid, cpu_stall, mem_en, dbg_rdata, model_mem[1]);
        end
        @(negedge clk);
        #2;
        checks++;
        if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 3'd7) begin
            failures++;
            $display("FAIL dl_store_after: stall=%b en=%b we=%b addr=%0d required 0 1 1 7", cpu_stall, mem_en, mem_we, mem_addr);
        end
        model_mem[7] = 16'h7777;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset_in_dbg_rd;
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd4;
        #2;
        checks++;
        if (dbg_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rst_dbg_grant: gnt=%b required 1", dbg_gnt);
        end
        @(negedge clk);
        rst = 1'b1; dbg_req = 1'b0;
        #2;
        checks++;
        if (dbg_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_dbg_in_reset: rvalid=%b en=%b required 0 0", dbg_rvalid, mem_en);
        end
        @(negedge clk);
        rst = 1'b0;
        reload_model();
        #2;
        checks++;
        if (dbg_rvalid !== 1'b0 || mem_en !== 1'b0 || int'(dut.starve_cnt_q) != 0) begin
            failures++;
            $display("FAIL rst_dbg_after: rvalid=%b en=%b cnt=%0d required 0 0 0", dbg_rvalid, mem_en, dut.starve_cnt_q);
        end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd5; cpu_wdata = 16'h0F0F;
        #2;
        checks++;
        if (mem_en !== 1'b1 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_dbg_idle_issue: en=%b stall=%b required 1 0", mem_en, cpu_stall);
        end
        model_mem[5] = 16'h0F0F;
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    // Model: owner of the in-flight read (0 none, 1 core, 2 debug) plus the
    // number of consecutive cycles debug has been kept waiting.
    task automatic test_random;
        int            owner = 0, waited = 0, age = 0;
        logic [DW-1:0] rd_val = '0;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        bit            e_en, e_we, e_stall, e_gnt, e_rv, dbg_first;
        bit            core_free = 1'b1, dbg_free = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (core_free) begin
                cpu_req   = ($urandom_range(0, 9) < 7);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = AW'($urandom);
                cpu_wdata = DW'($urandom);
            end
            if (dbg_free) begin
                dbg_req   = ($urandom_range(0, 9) < 3);
                dbg_we    = $urandom_range(0, 1) == 1;
                dbg_addr  = AW'($urandom);
                dbg_wdata = DW'($urandom);
                age = 0;
            end
            #2;
            e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_gnt = 0; e_rv = 0;
            e_stall = cpu_req;
            if (owner == 1) begin
                e_stall = 0;
            end else if (owner == 2) begin
                e_rv = 1;
            end else begin
                dbg_first = dbg_req && (!cpu_req || waited >= SM);
                if (dbg_first) begin
                    e_gnt = 1; e_en = 1; e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata;
                end else if (cpu_req) begin
                    e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; e_stall = !cpu_we;
                end
            end

            checks++;
            if ({mem_en, mem_we, cpu_stall, dbg_gnt, dbg_rvalid} !== {e_en, e_we, e_stall, e_gnt, e_rv}) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d: en/we/stall/gnt/rv=%b required %b", n,
                         {mem_en, mem_we, cpu_stall, dbg_gnt, dbg_rvalid}, {e_en, e_we, e_stall, e_gnt, e_rv});
            end
            if (e_en) begin
                checks++;
                if (mem_addr !== e_addr || (e_we && mem_wdata !== e_wd)) begin
                    failures++;
                    $display("FAIL rand_port n=%0d: addr=%0d wdata=%h required %0d %h", n, mem_addr, mem_wdata, e_addr, e_wd);
                end
            end
            if (owner == 1) begin
                checks++;
                if (cpu_rdata !== rd_val) begin
                    failures++;
                    $display("FAIL rand_cpu_rdata n=%0d: %h required %h", n, cpu_rdata, rd_val);
                end
            end
            if (owner == 2) begin
                checks++;
                if (dbg_rdata !== rd_val) begin
                    failures++;
                    $display("FAIL rand_dbg_rdata n=%0d: %h required %h", n, dbg_rdata, rd_val);
                end
            end
            if (dbg_req && dbg_gnt) begin
                checks++;
                if (age > SM + 2) begin
                    failures++;
                    $display("FAIL rand_dbg_latency n=%0d: granted after %0d cycles required <= %0d", n, age, SM + 2);
                end
            end else if (dbg_req && age == SM + 2) begin
                checks++;
                failures++;
                $display("FAIL rand_dbg_latency n=%0d: not granted after %0d cycles required <= %0d", n, age, SM + 2);
            end

            if (owner != 0) owner = 0;
            else if (e_en && !e_we) begin
                owner  = e_gnt ? 2 : 1;
                rd_val = model_mem[e_addr];
            end
            if (e_en && e_we) model_mem[e_addr] = e_wd;
            waited    = (dbg_req && !e_gnt) ? ((waited < SM) ? waited + 1 : SM) : 0;
            age++;
            core_free = !e_stall;
            dbg_free  = !dbg_req || e_gnt;
        end
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NW; i++) init_val[i] = DW'($urandom);
        test_reset();
        test_fixed_priority();
        test_core_store();
        test_core_load();
        test_dbg_read();
        test_starvation();
        test_dbg_during_load();
        test_reset_in_dbg_rd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shared data-memory port controller for the 16-bit RISC core. Arbitrates the single data-memory port between the core's load/store path and a debug/loader host, stalls the core while the port is busy, and enforces bounded debug latency with a starvation counter. Sits between `Datapath_Unit`'s memory request signals and the data memory, which has one synchronous-read port with 1-cycle read latency.

## Interface
- `ADDR_W`, 3: data-memory word-address width.
- `DATA_W`, 16: data width.
- `STARVE_MAX`, 4: consecutive denied debug cycles before debug is forced through. A value of 0 gives debug fixed priority.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: core access request (`mem_read | mem_write`).
- `cpu_we` in 1: core write (`mem_write`); a write takes precedence if both are set.
- `cpu_addr` in `ADDR_W`: core word address.
- `cpu_wdata` in `DATA_W`: core store data.
- `cpu_rdata` out `DATA_W`: load data; valid in the cycle a read completes.
- `cpu_stall` out 1: core must hold its PC and request this cycle.
- `dbg_req` in 1: debug request; must be held with `dbg_we`, `dbg_addr` and `dbg_wdata` stable until `dbg_gnt`.
- `dbg_we` in 1: debug write.
- `dbg_addr` in `ADDR_W`: debug word address.
- `dbg_wdata` in `DATA_W`: debug write data.
- `dbg_gnt` out 1: 1-cycle pulse; the request is issued to memory this cycle.
- `dbg_rdata` out `DATA_W`: read data; valid when `dbg_rvalid=1`.
- `dbg_rvalid` out 1: 1-cycle pulse, exactly 1 cycle after a debug read grant.
- `mem_en`, `mem_we` out 1: memory port enable and write enable.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: memory read data, valid 1 cycle after `mem_en & ~mem_we`.

## Operation
- **FSM states:**
  - `IDLE`: the port may issue.
  - `CPU_RD`: waiting for core read data.
  - `DBG_RD`: waiting for debug read data.
  - No issue occurs in `CPU_RD` or `DBG_RD`.
- **Arbitration (IDLE only), evaluated combinationally each cycle:**
  - `force = dbg_req & (starve_cnt == STARVE_MAX)`.
  - If `cpu_req & ~force`, grant the core.
  - Else if `dbg_req`, grant debug.
  - Else the port is idle (`mem_en=0`).
- **Core grant, write:**
  - `mem_en=1`, `mem_we=1`, `mem_addr=cpu_addr`, `mem_wdata=cpu_wdata`.
  - `cpu_stall=0`; the write completes this cycle and the state stays `IDLE`.
- **Core grant, read:**
  - `mem_en=1`, `mem_we=0`, `cpu_stall=1`; next state is `CPU_RD`.
  - In `CPU_RD`: `cpu_rdata=mem_rdata`, `cpu_stall=0`; next state is `IDLE`. The core's still-asserted `cpu_req` in this cycle is the completing access and is not reissued.
- **Debug grant:**
  - `dbg_gnt=1` and the memory port is driven from the `dbg_*` inputs.
  - A write completes this cycle.
  - A read moves to `DBG_RD`; in `DBG_RD`, `dbg_rvalid=1`, `dbg_rdata=mem_rdata`, and the next state is `IDLE`.
- **Core stall:** `cpu_stall=1` whenever `cpu_req=1` and the core is not granted this cycle or the core is in `CPU_RD`'s issue cycle. This includes cycles in `DBG_RD` and cycles lost to debug.
- **Starvation counter `starve_cnt`** (width `$clog2(STARVE_MAX+1)`, minimum 1):
  - Increments, saturating at `STARVE_MAX`, on each cycle with `dbg_req=1` and `dbg_gnt=0`.
  - Clears to 0 on `dbg_gnt` or when `dbg_req=0`.
- **Combinational outputs:** `mem_*`, `cpu_stall`, `cpu_rdata` and `dbg_rdata` are combinational from the state and inputs. `dbg_gnt` and `dbg_rvalid` are decoded from the state and arbitration result with no added latency.

## Timing
- **Reset values:** state `IDLE`, `starve_cnt=0`. Outputs `mem_en=0`, `mem_we=0`, `dbg_gnt=0`, `dbg_rvalid=0`, and `cpu_stall` equals `cpu_req` in the reset cycle.
- **Reset mid-read:** the pending read is discarded and no `dbg_rvalid` or read completion follows.
- **Uncontended latency:**
  - Core store: 1 cycle, no stall.
  - Core load: 2 cycles, with 1 stall cycle.
  - Debug write: grant in the request cycle.
  - Debug read: `dbg_rvalid` 1 cycle after grant.
- **Debug latency bound:** with the core requesting every cycle, a debug request is granted within `STARVE_MAX+2` cycles of assertion. The `+2` covers an in-flight core read.
- **Simultaneous requests:** in `IDLE` with `cpu_req` and `dbg_req` both set and `starve_cnt<STARVE_MAX`, the core wins.
- **`STARVE_MAX=0`:** debug always wins in `IDLE`.
- **Back-to-back:** at most one issue per cycle. Reads occupy 2 port cycles; writes occupy 1.
- **Address width:** addresses pass through unmodified, with no wrap or range checks.

## Test plan
- **Core store:** `rst` for 2 cycles, then core store `cpu_addr=3`, `cpu_wdata=16'hA5A5` → `mem_en=1`, `mem_we=1`, `mem_addr=3` that cycle, `cpu_stall=0`.
- **Core load:** core load from `addr=3` with memory holding `16'hA5A5` → cycle 0 `cpu_stall=1`, `mem_en=1`, `mem_we=0`; cycle 1 `cpu_stall=0`, `cpu_rdata=16'hA5A5`, `mem_en=0`.
- **Idle debug read:** debug read `addr=5` while the core is idle → `dbg_gnt=1` in cycle 0, `dbg_rvalid=1` with the memory contents in cycle 1, `dbg_rvalid=0` in cycle 2.
- **Starvation:** core stores every cycle, `dbg_req` asserted at cycle 0, `STARVE_MAX=4` → core granted in cycles 0–3, `dbg_gnt=1` and `cpu_stall=1` in cycle 4, `starve_cnt` back to 0 in cycle 5.
- **Debug read during core load:** debug read arrives while the core is in `CPU_RD` → no issue in that cycle; debug granted next cycle (`starve_cnt=1`) if the core is idle, and the core sees `cpu_stall=1` through `DBG_RD`.
- **Reset in DBG_RD:** assert `rst` while in `DBG_RD` → next cycle `dbg_rvalid=0`, `mem_en=0`, state `IDLE`, `starve_cnt=0`.
